// File: rtl/neuron_core_lif_param.sv
// neuron_core_lif_param
//   Time-multiplexed leaky integrate-and-fire core. N neurons share one 1R1W
//   state memory; each word is {disable, leak, thr, state}. Events arrive on a
//   valid/ready handshake, are read in cycle t, updated in cycle t+1 (stage S1)
//   and written back at the end of t+1. Spikes appear registered in t+2.
//   An OBI-style bus port shares the memory; events have priority, and a stall
//   counter throttles events once a bus request has waited MAX_STALL cycles.
//
// Ports
//   CLK, RSTN        clock, asynchronous active-low reset
//   evt_*            event handshake (tref = leak event, else synaptic weight)
//   spike_*          registered spike pulse, address and saturating count
//   busy_o           S1 occupied
//   bus_*            bus slave: request/grant, read/write, response
`timescale 1ns/1ps

module neuron_core_lif_param #(
  parameter int unsigned N         = 256,
  parameter int unsigned STATE_W   = 12,
  parameter int unsigned WEIGHT_W  = 8,
  parameter int unsigned LEAK_W    = 7,
  parameter int unsigned MAX_STALL = 8,
  localparam int unsigned AW       = $clog2(N),
  localparam int unsigned WORD_W   = 1 + LEAK_W + 2*STATE_W
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                evt_valid_i,
  output logic                evt_ready_o,
  input  logic                evt_tref_i,
  input  logic [AW-1:0]       evt_addr_i,
  input  logic [WEIGHT_W-1:0] evt_weight_i,
  output logic                spike_valid_o,
  output logic [AW-1:0]       spike_addr_o,
  output logic [15:0]         spike_cnt_o,
  output logic                busy_o,
  input  logic                bus_req_i,
  input  logic                bus_we_i,
  input  logic [AW-1:0]       bus_addr_i,
  input  logic [WORD_W-1:0]   bus_wdata_i,
  output logic                bus_gnt_o,
  output logic                bus_rvalid_o,
  output logic [WORD_W-1:0]   bus_rdata_o
);

  // Two guard bits: one for the sign of a negative result, one for overflow.
  localparam int unsigned SUM_W    = STATE_W + 2;
  localparam int unsigned STALL_W  = $clog2(MAX_STALL + 1);
  localparam int unsigned THR_LSB  = STATE_W;
  localparam int unsigned LEAK_LSB = 2*STATE_W;
  localparam int unsigned DIS_BIT  = WORD_W - 1;

  logic [WORD_W-1:0]   r_mem [N];

  logic                r_s1_valid;
  logic [AW-1:0]       r_s1_addr;
  logic                r_s1_tref;
  logic [WEIGHT_W-1:0] r_s1_weight;
  logic [WORD_W-1:0]   r_s1_word;

  logic                r_spike_valid;
  logic [AW-1:0]       r_spike_addr;
  logic [15:0]         r_spike_cnt;
  logic                r_bus_rvalid;
  logic [WORD_W-1:0]   r_bus_rdata;
  logic [STALL_W-1:0]  r_stall;

  logic                w_evt_acc;
  logic                w_dis;
  logic [LEAK_W-1:0]   w_leak;
  logic [STATE_W-1:0]  w_thr;
  logic [STATE_W-1:0]  w_state;
  logic [SUM_W-1:0]    w_wext;
  logic [SUM_W-1:0]    w_sum;
  logic [STATE_W-1:0]  w_clamp;
  logic                w_fire;
  logic [WORD_W-1:0]   w_next;
  logic [WORD_W-1:0]   w_evt_rdata;
  logic [WORD_W-1:0]   w_bus_rdata;

  // Handshake and bus arbitration
  assign evt_ready_o = (r_stall < STALL_W'(MAX_STALL));
  assign w_evt_acc   = evt_valid_i && evt_ready_o;
  assign bus_gnt_o   = bus_req_i && !w_evt_acc && !(bus_we_i && r_s1_valid);

  // S1 field extraction
  assign w_dis   = r_s1_word[DIS_BIT];
  assign w_leak  = r_s1_word[LEAK_LSB +: LEAK_W];
  assign w_thr   = r_s1_word[THR_LSB +: STATE_W];
  assign w_state = r_s1_word[0 +: STATE_W];
  assign w_wext  = SUM_W'($signed(r_s1_weight));

  // S1 update: integrate or leak, clamp to [0, 2^STATE_W-1], then threshold
  always_comb begin
    w_sum   = '0;
    w_clamp = '0;
    w_fire  = 1'b0;
    w_next  = r_s1_word;
    if (r_s1_tref) w_sum = SUM_W'(w_state) - SUM_W'(w_leak);
    else           w_sum = SUM_W'(w_state) + w_wext;
    if (w_sum[SUM_W-1])                    w_clamp = '0;
    else if (w_sum[SUM_W-2:STATE_W] != '0) w_clamp = '1;
    else                                   w_clamp = w_sum[STATE_W-1:0];
    w_fire = !w_dis && (w_thr != '0) && (w_clamp >= w_thr);
    if (!w_dis) w_next[0 +: STATE_W] = w_fire ? '0 : w_clamp;
  end

  // Reads of the address S1 is writing this cycle see the new word
  assign w_evt_rdata = (r_s1_valid && (r_s1_addr == evt_addr_i)) ? w_next : r_mem[evt_addr_i];
  assign w_bus_rdata = (r_s1_valid && (r_s1_addr == bus_addr_i)) ? w_next : r_mem[bus_addr_i];

  // State memory: grant logic keeps the two write sources exclusive
  always_ff @(posedge CLK) begin
    if (r_s1_valid)               r_mem[r_s1_addr]  <= w_next;
    else if (bus_gnt_o && bus_we_i) r_mem[bus_addr_i] <= bus_wdata_i;
  end

  // S1 pipeline register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_s1_valid  <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_tref   <= 1'b0;
      r_s1_weight <= '0;
      r_s1_word   <= '0;
    end else begin
      r_s1_valid <= w_evt_acc;
      if (w_evt_acc) begin
        r_s1_addr   <= evt_addr_i;
        r_s1_tref   <= evt_tref_i;
        r_s1_weight <= evt_weight_i;
        r_s1_word   <= w_evt_rdata;
      end
    end
  end

  // Spike output and saturating counter
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_spike_valid <= 1'b0;
      r_spike_addr  <= '0;
      r_spike_cnt   <= '0;
    end else begin
      r_spike_valid <= r_s1_valid && w_fire;
      if (r_s1_valid && w_fire) begin
        r_spike_addr <= r_s1_addr;
        if (r_spike_cnt != '1) r_spike_cnt <= r_spike_cnt + 16'(1);
      end
    end
  end

  // Bus response and starvation counter
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_bus_rvalid <= 1'b0;
      r_bus_rdata  <= '0;
      r_stall      <= '0;
    end else begin
      r_bus_rvalid <= bus_gnt_o;
      if (bus_gnt_o) r_bus_rdata <= bus_we_i ? '0 : w_bus_rdata;
      if (!bus_req_i || bus_gnt_o)             r_stall <= '0;
      else if (r_stall < STALL_W'(MAX_STALL))  r_stall <= r_stall + STALL_W'(1);
    end
  end

  assign spike_valid_o = r_spike_valid;
  assign spike_addr_o  = r_spike_addr;
  assign spike_cnt_o   = r_spike_cnt;
  assign busy_o        = r_s1_valid;
  assign bus_rvalid_o  = r_bus_rvalid;
  assign bus_rdata_o   = r_bus_rdata;

endmodule

// File: tb/tb_neuron_core_lif_param.sv
// tb_neuron_core_lif_param
//   Directed and random stimulus for neuron_core_lif_param at default
//   parameters, checked against an array-based neuron model.
`timescale 1ns/1ps

module tb_neuron_core_lif_param;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        evt_valid_i, evt_ready_o, evt_tref_i;
  logic [7:0]  evt_addr_i;
  logic [7:0]  evt_weight_i;
  logic        spike_valid_o;
  logic [7:0]  spike_addr_o;
  logic [15:0] spike_cnt_o;
  logic        busy_o;
  logic        bus_req_i, bus_we_i;
  logic [7:0]  bus_addr_i;
  logic [31:0] bus_wdata_i;
  logic        bus_gnt_o, bus_rvalid_o;
  logic [31:0] bus_rdata_o;

  neuron_core_lif_param dut (
    .CLK(CLK), .RSTN(RSTN),
    .evt_valid_i(evt_valid_i), .evt_ready_o(evt_ready_o), .evt_tref_i(evt_tref_i),
    .evt_addr_i(evt_addr_i), .evt_weight_i(evt_weight_i),
    .spike_valid_o(spike_valid_o), .spike_addr_o(spike_addr_o), .spike_cnt_o(spike_cnt_o),
    .busy_o(busy_o),
    .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i),
    .bus_wdata_i(bus_wdata_i), .bus_gnt_o(bus_gnt_o),
    .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o)
  );

  always #5 CLK = ~CLK;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_fail = 0;
  logic [31:0] m_mem [256];
  int          m_cnt = 0;
  bit          exp_v [4];
  int          exp_a [4];
  int          cyc = 0;
  bit          chk_spk = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mk(input bit d, input int lk, input int th, input int st);
    return {d, 7'(lk), 12'(th), 12'(st)};
  endfunction

  // Neuron semantics applied in acceptance order; spike expected two cycles later
  task automatic model_apply(input int a, input bit tref, input int w);
    logic [31:0] wd;
    int v, thr, lk;
    bit spk;
    wd  = m_mem[a];
    lk  = int'(wd[30:24]);
    thr = int'(wd[23:12]);
    v   = int'(wd[11:0]);
    spk = 0;
    if (!wd[31]) begin
      v = tref ? v - lk : v + w;
      if (v < 0) v = 0;
      if (v > 4095) v = 4095;
      if (thr != 0 && v >= thr) begin spk = 1; v = 0; end
      m_mem[a][11:0] = 12'(v);
    end
    exp_v[(cyc+2)%4] = spk;
    exp_a[(cyc+2)%4] = a;
    if (spk && m_cnt < 65535) m_cnt++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (chk_spk) begin
      check("spike_valid", {63'd0, spike_valid_o}, {63'd0, exp_v[cyc%4]});
      if (exp_v[cyc%4]) check("spike_addr", 64'(spike_addr_o), 64'(exp_a[cyc%4]));
    end
    exp_v[cyc%4] = 0;
  endtask

  task automatic send_evt(input int a, input bit tref, input int w);
    int k;
    evt_valid_i  = 1'b1;
    evt_addr_i   = 8'(a);
    evt_tref_i   = tref;
    evt_weight_i = 8'(w);
    #1;
    k = 0;
    while (!evt_ready_o && k < 50) begin tick(); #1; k++; end
    check("evt_ready_wait", {63'd0, evt_ready_o}, 64'd1);
    model_apply(a, tref, w);
    tick();
    evt_valid_i = 1'b0;
  endtask

  task automatic bus_op(input bit we, input int a, input logic [31:0] wd, output logic [31:0] rd);
    int k;
    bus_req_i   = 1'b1;
    bus_we_i    = we;
    bus_addr_i  = 8'(a);
    bus_wdata_i = wd;
    #1;
    k = 0;
    while (!bus_gnt_o && k < 50) begin tick(); #1; k++; end
    check("bus_gnt_wait", {63'd0, bus_gnt_o}, 64'd1);
    if (we) m_mem[a] = wd;
    tick();
    bus_req_i = 1'b0;
    check("bus_rvalid", {63'd0, bus_rvalid_o}, 64'd1);
    rd = bus_rdata_o;
    if (we) check("bus_wr_rdata", 64'(bus_rdata_o), 64'd0);
  endtask

  task automatic bus_wr(input int a, input logic [31:0] wd);
    logic [31:0] rd;
    bus_op(1'b1, a, wd, rd);
  endtask

  task automatic read_chk(input string tag, input int a);
    logic [31:0] rd;
    bus_op(1'b0, a, 32'd0, rd);
    check(tag, 64'(rd), 64'(m_mem[a]));
  endtask

  task automatic idle(input int n);
    evt_valid_i = 1'b0;
    bus_req_i   = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_spike_valid"}, {63'd0, spike_valid_o}, 64'd0);
    check({tag, "_spike_addr"}, 64'(spike_addr_o), 64'd0);
    check({tag, "_spike_cnt"}, 64'(spike_cnt_o), 64'd0);
    check({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    check({tag, "_rvalid"}, {63'd0, bus_rvalid_o}, 64'd0);
    check({tag, "_rdata"}, 64'(bus_rdata_o), 64'd0);
  endtask

  initial begin
    logic [31:0] wd;
    int a, w;
    bit tr;

    RSTN = 1'b0;
    evt_valid_i = 0; evt_tref_i = 0; evt_addr_i = 0; evt_weight_i = 0;
    bus_req_i = 0; bus_we_i = 0; bus_addr_i = 0; bus_wdata_i = 0;
    for (int i = 0; i < 4; i++) begin exp_v[i] = 0; exp_a[i] = 0; end

    // Reset state
    #3;
    check_reset_outputs("rst");
    check("rst_ready", {63'd0, evt_ready_o}, 64'd1);
    check("rst_gnt", {63'd0, bus_gnt_o}, 64'd0);
    tick(); tick();
    RSTN = 1'b1;
    tick();
    chk_spk = 1;

    // Back-to-back accumulation to threshold on neuron 5
    bus_wr(5, mk(0, 2, 100, 0));
    send_evt(5, 0, 60);
    send_evt(5, 0, 50);
    idle(3);
    read_chk("n5_state", 5);
    check("n5_state_zero", 64'(m_mem[5][11:0]), 64'd0);
    check("n5_spike_cnt", 64'(spike_cnt_o), 64'd1);

    // Upper clamp with thr=0, then repeated negative weights clamp at 0
    bus_wr(7, mk(0, 0, 0, 4095));
    send_evt(7, 0, 127);
    idle(2);
    read_chk("n7_upper", 7);
    check("n7_upper_const", 64'(m_mem[7]), 64'(mk(0, 0, 0, 4095)));
    for (int i = 0; i < 40; i++) send_evt(7, 0, -128);
    idle(2);
    read_chk("n7_lower", 7);
    check("n7_lower_const", 64'(m_mem[7][11:0]), 64'd0);

    // Leak clamp, then disabled neuron keeps its word
    bus_wr(9, mk(0, 5, 50, 3));
    send_evt(9, 1, 0);
    idle(2);
    read_chk("n9_leak", 9);
    bus_wr(9, mk(1, 5, 50, 40));
    send_evt(9, 0, 100);
    idle(3);
    read_chk("n9_disabled", 9);
    check("n9_disabled_const", 64'(m_mem[9]), 64'(mk(1, 5, 50, 40)));
    check("n9_spike_cnt", 64'(spike_cnt_o), 64'(m_cnt));

    // Preload neurons 16..31 for the random phases
    for (int n = 16; n < 32; n++)
      bus_wr(n, mk($urandom_range(0, 7) == 0, $urandom_range(0, 127),
                   $urandom_range(0, 600), $urandom_range(0, 300)));
    idle(2);

    // Starvation guard: continuous events with a pending bus read
    bus_req_i  = 1'b1;
    bus_we_i   = 1'b0;
    bus_addr_i = 8'd20;
    for (int k = 0; k < 9; k++) begin
      a  = (k == 7) ? 20 : 20 + $urandom_range(0, 3);
      tr = ($urandom_range(0, 3) == 0);
      w  = $urandom_range(0, 255) - 128;
      evt_valid_i = 1'b1; evt_addr_i = 8'(a); evt_tref_i = tr; evt_weight_i = 8'(w);
      #1;
      check("stall_ready", {63'd0, evt_ready_o}, {63'd0, k < 8});
      check("stall_gnt", {63'd0, bus_gnt_o}, {63'd0, k == 8});
      if (evt_ready_o) model_apply(a, tr, w);
      tick();
    end
    evt_valid_i = 1'b0;
    bus_req_i   = 1'b0;
    check("stall_rvalid", {63'd0, bus_rvalid_o}, 64'd1);
    check("stall_rdata", 64'(bus_rdata_o), 64'(m_mem[20]));
    #1;
    check("stall_ready_after", {63'd0, evt_ready_o}, 64'd1);
    idle(2);

    // Bus write waits for S1 holding the same neuron
    bus_wr(3, mk(0, 1, 200, 10));
    send_evt(3, 0, 20);
    bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = 8'd3; bus_wdata_i = mk(0, 4, 300, 77);
    #1;
    check("coll_gnt_withheld", {63'd0, bus_gnt_o}, 64'd0);
    tick();
    #1;
    check("coll_gnt", {63'd0, bus_gnt_o}, 64'd1);
    m_mem[3] = mk(0, 4, 300, 77);
    tick();
    bus_req_i = 1'b0;
    check("coll_rvalid", {63'd0, bus_rvalid_o}, 64'd1);
    check("coll_rdata", 64'(bus_rdata_o), 64'd0);
    idle(2);
    read_chk("coll_final", 3);
    check("coll_final_const", 64'(m_mem[3]), 64'(mk(0, 4, 300, 77)));

    // Random events with gaps, periodic read-back
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send_evt(16 + $urandom_range(0, 15), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 255) - 128);
      if (i % 50 == 49) begin
        idle(2);
        read_chk("rand_read", 16 + $urandom_range(0, 15));
        check("rand_spike_cnt", 64'(spike_cnt_o), 64'(m_cnt));
      end
    end
    idle(2);
    for (int n = 16; n < 32; n++) read_chk("rand_final", n);

    // Reset during the S1 cycle of a spiking event
    bus_wr(5, mk(0, 2, 100, 90));
    idle(1);
    evt_valid_i = 1'b1; evt_addr_i = 8'd5; evt_tref_i = 1'b0; evt_weight_i = 8'd20;
    #1;
    check("rst_mid_ready", {63'd0, evt_ready_o}, 64'd1);
    tick();
    evt_valid_i = 1'b0;
    check("rst_mid_busy", {63'd0, busy_o}, 64'd1);
    chk_spk = 0;
    #2;
    RSTN = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick(); tick();
    check_reset_outputs("rst_mid_hold");
    RSTN = 1'b1;
    for (int i = 0; i < 4; i++) exp_v[i] = 0;
    m_cnt = 0;
    tick();
    chk_spk = 1;
    read_chk("rst_mid_nowrite", 5);
    check("rst_mid_nowrite_const", 64'(m_mem[5]), 64'(mk(0, 2, 100, 90)));
    check("rst_mid_cnt", 64'(spike_cnt_o), 64'd0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
